// File: rtl/pio_input_responder_pkg.sv
// Shared constants for the pushbutton/switch input responder: register map and field offsets.
package pio_input_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE = 2'd2;
   localparam logic [1:0] ADDR_ID   = 2'd3;

   localparam int SW_LSB = 8;

   // 1 ms at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/pio_input_responder_if.sv
// Avalon-MM slave bus seen by the input responder; no waitrequest, read latency 1.
interface pio_input_responder_if;

   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );

endinterface

// File: rtl/pio_input_responder_debounce.sv
// One-bit 2-flop synchronizer plus debounce: a new level is accepted after
// DEBOUNCE_CYCLES consecutive synced samples that disagree with the current output.
module input_debounce
   import pio_input_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic debounced
);

   localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          synced;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta      <= RESET_VAL;
         synced    <= RESET_VAL;
         cnt       <= '0;
         debounced <= RESET_VAL;
      end else begin
         meta   <= raw;
         synced <= meta;
         // Any agreement (including a bounce back) restarts the stability count.
         if (synced == debounced) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            debounced <= synced;
            cnt       <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pio_input_responder.sv
// Avalon-MM input peripheral: debounced buttons/switches, sticky press capture
// with write-1-to-clear, and a registered maskable level IRQ.
module pio_input_responder
   import pio_input_pkg::*;
#(
   parameter int          NUM_BUTTONS     = 4,
   parameter int          NUM_SWITCHES    = 10,
   parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [15:0] ID_VALUE        = 16'hB5A1
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   input  logic [NUM_BUTTONS-1:0]  buttons_n,
   input  logic [NUM_SWITCHES-1:0] switches,
   pio_input_responder_if.slave    avs,
   output logic                    irq
);

   logic [NUM_BUTTONS-1:0]  btn_deb_n;
   logic [NUM_BUTTONS-1:0]  pressed;
   logic [NUM_BUTTONS-1:0]  pressed_q;
   logic [NUM_SWITCHES-1:0] sw_deb;
   logic [NUM_BUTTONS-1:0]  edge_cap;
   logic [NUM_BUTTONS-1:0]  irq_mask;
   logic [NUM_BUTTONS-1:0]  edge_clr;
   logic [31:0]             rd_mux;
   logic [31:0]             readdata;
   logic                    wr_mask;
   logic                    wr_edge;
   logic                    wdata_unused;

   // Buttons are debounced in their raw active-low form so reset lands on "released".
   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb (
         .clk       (clk_clk),
         .rst_n     (reset_reset_n),
         .raw       (buttons_n[i]),
         .debounced (btn_deb_n[i])
      );
   end

   for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
      input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_deb (
         .clk       (clk_clk),
         .rst_n     (reset_reset_n),
         .raw       (switches[i]),
         .debounced (sw_deb[i])
      );
   end

   assign pressed      = ~btn_deb_n;
   assign wr_mask      = avs.avs_write && (avs.avs_address == ADDR_MASK);
   assign wr_edge      = avs.avs_write && (avs.avs_address == ADDR_EDGE);
   assign edge_clr     = wr_edge ? avs.avs_writedata[NUM_BUTTONS-1:0] : '0;
   assign wdata_unused = ^avs.avs_writedata[31:NUM_BUTTONS];

   always_comb begin
      rd_mux = '0;
      case (avs.avs_address)
         ADDR_DATA: begin
            rd_mux[NUM_BUTTONS-1:0]        = pressed;
            rd_mux[SW_LSB +: NUM_SWITCHES] = sw_deb;
         end
         ADDR_MASK: rd_mux[NUM_BUTTONS-1:0] = irq_mask;
         ADDR_EDGE: rd_mux[NUM_BUTTONS-1:0] = edge_cap;
         default:   rd_mux = {8'(NUM_SWITCHES), 8'(NUM_BUTTONS), ID_VALUE};
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pressed_q <= '0;
         edge_cap  <= '0;
         irq_mask  <= '0;
         readdata  <= '0;
         irq       <= 1'b0;
      end else begin
         pressed_q <= pressed;
         if (wr_mask) begin
            irq_mask <= avs.avs_writedata[NUM_BUTTONS-1:0];
         end
         // A press edge in the same cycle as its W1C keeps the bit set.
         edge_cap <= (edge_cap & ~edge_clr) | (pressed & ~pressed_q);
         irq      <= |(edge_cap & irq_mask);
         if (avs.avs_read) begin
            readdata <= rd_mux;
         end
      end
   end

   assign avs.avs_readdata = readdata;

endmodule
